// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: address/data widths,
// fetch sequencer states and the buffered {pc, inst} entry.
package fetch_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned INST_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO of fetch entries between the memory
// response and decode. Flush empties it and dominates a same-cycle push.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  fetch_entry_t  push_data,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output logic          head_valid,
   output fetch_entry_t  head_data
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      do_pop   = pop & (count_q != '0) & ~flush;
      // A push into a full buffer is only taken when the head leaves this cycle.
      do_push  = push & ~flush & (~full | do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   always_comb begin
      count      = count_q;
      head_valid = (count_q != '0);
      head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: owns the PC, drives the instruction memory address,
// tracks the one-cycle read latency and feeds decode through fetch_buffer.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] imem_a,
   input  logic [INST_W-1:0] imem_rd,
   output logic              inst_valid,
   output logic [INST_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   input  logic              inst_ready
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned OW = CW + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              inflight_q, inflight_d;
   logic              issue;
   logic              deq;
   logic              space;
   logic [OW-1:0]     occ;
   logic [CW-1:0]     buf_count;
   logic              head_valid;
   fetch_entry_t      head_entry;
   fetch_entry_t      push_entry;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect) begin
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE:    if (start)          state_d = RUN;
            RUN:     if (halt)           state_d = HALTED;
            HALTED:  if (start && !halt) state_d = RUN;
            default:                     state_d = IDLE;
         endcase
      end
   end

   // Issue follows the state being entered, so the start cycle itself fetches;
   // a redirect always issues because the buffer and in-flight slot are flushed.
   always_comb begin
      deq      = head_valid & inst_ready;
      occ      = OW'(buf_count) + OW'(inflight_q) - OW'(deq);
      space    = (occ < OW'(DEPTH));
      issue    = redirect | ((state_d == RUN) & space);
      imem_a   = redirect ? redirect_pc : pc_q;
      pc_d     = pc_q;
      if (redirect)   pc_d = redirect_pc + ADDR_W'(1);
      else if (issue) pc_d = pc_q + ADDR_W'(1);
      inflight_d = issue;
      req_pc_d   = issue ? imem_a : req_pc_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
      end
   end

   assign push_entry = '{pc: req_pc_q, inst: imem_rd};

   // A redirect flush also squashes the response arriving this cycle.
   fetch_buffer #(
      .DEPTH(DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (push_entry),
      .pop       (deq),
      .flush     (redirect),
      .count     (buf_count),
      .head_valid(head_valid),
      .head_data (head_entry)
   );

   assign inst_valid = head_valid;
   assign inst       = head_entry.inst;
   assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized traffic against a delivered-instruction-stream reference model.
module tb_instruction_fetch_unit;

   localparam logic [15:0] RST_PC = 16'h0010;

   logic        clk = 1'b0;
   logic        rst_n, start, halt, redirect, inst_ready;
   logic [15:0] redirect_pc, imem_a, inst_pc;
   logic [31:0] imem_rd, inst;
   logic        inst_valid;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   int unsigned n_acc = 0;

   // Reference model state: next pc decode must see, plus pending timing checks.
   logic [15:0] exp_pc;
   logic        a1, a2, hold, rchk;
   logic [15:0] a1pc, a2pc, hold_pc, snap_a;
   logic [31:0] hold_inst;

   instruction_fetch_unit #(
      .RESET_PC(RST_PC),
      .DEPTH   (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .halt       (halt),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_a     (imem_a),
      .imem_rd    (imem_rd),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [15:0] a);
      return {a ^ 16'h5A3C, ~a};
   endfunction

   // Synchronous instruction memory: one-cycle read latency.
   always @(posedge clk) imem_rd <= memf(imem_a);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model();
      if (rchk) begin
         chk("rst_valid", 32'(inst_valid), 32'd0);
         chk("rst_inst", inst, 32'd0);
         chk("rst_inst_pc", 32'(inst_pc), 32'd0);
         if (!redirect) chk("rst_imem_a", 32'(imem_a), 32'(RST_PC));
      end
      if (a2) begin
         chk("redir_target_valid", 32'(inst_valid), 32'd1);
         chk("redir_target_pc", 32'(inst_pc), 32'(a2pc));
      end
      if (a1) chk("redir_old_path_gone", 32'(inst_valid), 32'd0);
      if (hold) begin
         chk("hold_valid", 32'(inst_valid), 32'd1);
         chk("hold_pc", 32'(inst_pc), 32'(hold_pc));
         chk("hold_inst", inst, hold_inst);
      end
      if (!rst_n) begin
         exp_pc = RST_PC;
         a1 = 1'b0; a2 = 1'b0; hold = 1'b0; rchk = 1'b1;
      end else begin
         rchk = 1'b0;
         if (inst_valid && inst_ready) begin
            chk("seq_pc", 32'(inst_pc), 32'(exp_pc));
            chk("seq_inst", inst, memf(exp_pc));
            exp_pc = exp_pc + 16'd1;
            n_acc++;
         end
         if (redirect) begin
            chk("redir_imem_a", 32'(imem_a), 32'(redirect_pc));
            exp_pc = redirect_pc;
         end
         a2 = a1 && !redirect;
         a2pc = a1pc;
         a1 = redirect;
         a1pc = redirect_pc;
         hold = inst_valid && !inst_ready && !redirect;
         hold_pc = inst_pc;
         hold_inst = inst;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect = 1'b0;
      redirect_pc = '0; inst_ready = 1'b1;
      exp_pc = RST_PC; a1 = 1'b0; a2 = 1'b0; hold = 1'b0; rchk = 1'b0;
      a1pc = '0; a2pc = '0; hold_pc = '0; hold_inst = '0; snap_a = '0;
      @(posedge clk); #1;
      tick(); tick();

      // Cycle 0 idle, start in cycle 1, first instruction in cycle 3.
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("lat_c2_empty", 32'(inst_valid), 32'd0);
      tick();
      chk("lat_c3_valid", 32'(inst_valid), 32'd1);
      chk("lat_c3_pc", 32'(inst_pc), 32'h0010);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stream_valid", 32'(inst_valid), 32'd1);
      end

      // Decode stall for five cycles.
      inst_ready = 1'b0;
      tick(); tick();
      snap_a = imem_a;
      tick(); tick(); tick();
      chk("stall_no_issue", 32'(imem_a), 32'(snap_a));
      chk("stall_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("release_valid", 32'(inst_valid), 32'd1);
      end

      // Redirect while buffer and in-flight slot are occupied.
      inst_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 16'h0200;
      tick();
      redirect = 1'b0; inst_ready = 1'b1;
      chk("redir_t1_empty", 32'(inst_valid), 32'd0);
      tick();
      chk("redir_t2_pc", 32'(inst_pc), 32'h0200);
      tick(); tick();

      // PC wrap-around.
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      redirect = 1'b0;
      tick();
      chk("wrap_fffe", 32'(inst_pc), 32'hFFFE);
      tick();
      chk("wrap_ffff", 32'(inst_pc), 32'hFFFF);
      tick();
      chk("wrap_0000", 32'(inst_pc), 32'h0000);
      chk("wrap_valid", 32'(inst_valid), 32'd1);
      tick(); tick();

      // Halt while streaming, then resume.
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("halt_inflight_delivered", 32'(inst_valid), 32'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("halt_drained", 32'(inst_valid), 32'd0);
         tick();
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("resume_valid", 32'(inst_valid), 32'd1);
      tick(); tick(); tick();

      // One-cycle reset mid-stream.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_valid", 32'(inst_valid), 32'd0);
      chk("midrst_imem_a", 32'(imem_a), 32'(RST_PC));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("midrst_idle", 32'(inst_valid), 32'd0);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("restart_pc", 32'(inst_pc), 32'(RST_PC));
      chk("restart_valid", 32'(inst_valid), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         redirect   = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFF8 + 16'($urandom_range(0, 7));
         else                           redirect_pc = 16'($urandom);
         halt       = ($urandom_range(0, 39) == 0);
         start      = ($urandom_range(0, 7) == 0);
         rst_n      = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst_n = 1'b1; redirect = 1'b0; halt = 1'b0; start = 1'b0; inst_ready = 1'b1;
      tick();
      chk("random_progress", 32'(n_acc > 800), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
